// File: rtl/rf_text_font_loader.sv
// Font loader: packs a glyph byte stream into 32-bit byte-selected writes to
// character RAM, one octa-byte-aligned slot per glyph at fontAddress + code*stride.
module rf_text_font_loader #(
    parameter int pCodeWidth = 13
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [15:0]           fontAddress_i,
    input  logic [5:0]            maxScanpix_i,
    input  logic [5:0]            maxscanline_i,
    input  logic [pCodeWidth-1:0] first_code_i,
    input  logic [pCodeWidth:0]   char_count_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [7:0]            in_dat_i,
    output logic                  cs_o,
    output logic                  we_o,
    output logic [3:0]            sel_o,
    output logic [13:0]           adr_o,
    output logic [31:0]           dat_o,
    input  logic                  ack_i,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam int MulW = pCodeWidth + 10;
    localparam logic [pCodeWidth:0] CntZero = {(pCodeWidth+1){1'b0}};
    localparam logic [pCodeWidth:0] CntOne  = {{pCodeWidth{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t              state_r;
    logic [9:0]          char_size_r;
    logic [9:0]          stride_r;
    logic [15:0]         glyph_base_r;
    logic [pCodeWidth:0] remaining_r;
    logic [9:0]          offset_r;
    logic [3:0]          sel_r;
    logic [31:0]         dat_r;
    logic [13:0]         adr_r;
    logic                cs_r;
    logic                ready_r;
    logic                busy_r;
    logic                done_r;

    logic [3:0]      scan_width_s;
    logic [9:0]      char_size_s;
    logic [6:0]      char_size8_s;
    logic [9:0]      stride_s;
    logic [MulW-1:0] mult_s;
    logic [15:0]     start_base_s;
    logic [15:0]     byte_addr_s;
    logic [1:0]      lane_s;
    logic [9:0]      offset_next_s;
    logic            unused_s;

    // Glyph geometry is computed straight from the start inputs so the first
    // byte can be accepted the cycle after start_i.
    assign scan_width_s  = {1'b0, maxScanpix_i[5:3]} + {3'b000, |maxScanpix_i[2:0]};
    assign char_size_s   = {4'd0, maxscanline_i} * {6'd0, scan_width_s};
    assign char_size8_s  = char_size_s[9:3] + {6'd0, |char_size_s[2:0]};
    assign stride_s      = {char_size8_s, 3'b000};
    assign mult_s        = MulW'(first_code_i) * MulW'(stride_s);
    assign start_base_s  = {fontAddress_i[15:3], 3'b000} + mult_s[15:0];
    assign byte_addr_s   = glyph_base_r + {6'd0, offset_r};
    assign lane_s        = byte_addr_s[1:0];
    assign offset_next_s = offset_r + 10'd1;
    assign unused_s      = ^{fontAddress_i[2:0], mult_s[MulW-1:16]};

    assign in_ready_o = ready_r;
    assign cs_o       = cs_r;
    assign we_o       = cs_r;
    assign sel_o      = sel_r;
    assign adr_o      = adr_r;
    assign dat_o      = dat_r;
    assign busy_o     = busy_r;
    assign done_o     = done_r;

    // Load sequencer: gathers bytes into a word, then holds the write until ack.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r      <= ST_IDLE;
            char_size_r  <= 10'd0;
            stride_r     <= 10'd0;
            glyph_base_r <= 16'd0;
            remaining_r  <= CntZero;
            offset_r     <= 10'd0;
            sel_r        <= 4'd0;
            dat_r        <= 32'd0;
            adr_r        <= 14'd0;
            cs_r         <= 1'b0;
            ready_r      <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (start_i) begin
                        if ((char_count_i == CntZero) || (char_size_s == 10'd0)) begin
                            done_r <= 1'b1;
                        end else begin
                            state_r      <= ST_FILL;
                            ready_r      <= 1'b1;
                            busy_r       <= 1'b1;
                            char_size_r  <= char_size_s;
                            stride_r     <= stride_s;
                            glyph_base_r <= start_base_s;
                            remaining_r  <= char_count_i;
                            offset_r     <= 10'd0;
                            sel_r        <= 4'd0;
                            dat_r        <= 32'd0;
                        end
                    end
                end
                ST_FILL: begin
                    if (in_valid_i && ready_r) begin
                        dat_r[{lane_s, 3'b000} +: 8] <= in_dat_i;
                        sel_r[lane_s]                <= 1'b1;
                        offset_r                     <= offset_next_s;
                        adr_r                        <= byte_addr_s[15:2];
                        if ((lane_s == 2'd3) || (offset_next_s == char_size_r)) begin
                            state_r <= ST_WRITE;
                            cs_r    <= 1'b1;
                            ready_r <= 1'b0;
                        end
                    end
                end
                ST_WRITE: begin
                    if (ack_i) begin
                        cs_r  <= 1'b0;
                        sel_r <= 4'd0;
                        dat_r <= 32'd0;
                        if (offset_r == char_size_r) begin
                            offset_r     <= 10'd0;
                            glyph_base_r <= glyph_base_r + {6'd0, stride_r};
                            remaining_r  <= remaining_r - CntOne;
                            if (remaining_r == CntOne) begin
                                state_r <= ST_DONE;
                                done_r  <= 1'b1;
                            end else begin
                                state_r <= ST_FILL;
                                ready_r <= 1'b1;
                            end
                        end else begin
                            state_r <= ST_FILL;
                            ready_r <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    cs_r    <= 1'b0;
                    ready_r <= 1'b0;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/rf_text_font_loader.md
# rf_text_font_loader

Bus-master font loader that packs a byte stream of glyph scanline data into the text controller's character RAM. It uses the layout the character RAM's dot-clock reader unpacks: each glyph occupies an octa-byte-aligned slot at `fontAddress + code*stride`. The loader sits between a font source (boot ROM streamer or DMA FIFO) and the character RAM's 32-bit CPU-side write port. It issues byte-selected 32-bit writes with an ack handshake.

## Interface
Parameters:
- pCodeWidth, 13: width of character code fields.

Ports:
- clk_i  in  1  system clock; the only clock.
- rst_i  in  1  reset, synchronous, active-high.
- start_i  in  1  one-cycle pulse that begins a load; ignored while busy_o=1.
- fontAddress_i  in  16  font base byte address; bits [2:0] are treated as 0.
- maxScanpix_i  in  6  glyph width in pixels.
- maxscanline_i  in  6  scanlines per glyph.
- first_code_i  in  pCodeWidth  code of the first glyph loaded.
- char_count_i  in  pCodeWidth+1  number of glyphs to load.
- in_valid_i  in  1  stream byte valid.
- in_ready_o  out  1  loader accepts a byte this cycle when valid & ready.
- in_dat_i  in  8  glyph byte. Row-major, scan_width bytes per scanline, leftmost pixel byte first.
- cs_o  out  1  bus cycle active.
- we_o  out  1  write strobe; equals cs_o.
- sel_o  out  4  byte lane selects.
- adr_o  out  14  word address, byte address bits [15:2].
- dat_o  out  32  write data; byte k is on [8k+7:8k].
- ack_i  in  1  write complete; sampled only while cs_o=1.
- busy_o  out  1  load in progress.
- done_o  out  1  one-cycle pulse when the last write is acked.

## Operation
- Size arithmetic is latched at start_i and held for the whole load:
  - scan_width = maxScanpix[5:3] + |maxScanpix[2:0] (4 bits).
  - char_size = maxscanline*scan_width (10 bits).
  - char_size8 = char_size[9:3] + |char_size[2:0].
  - stride = char_size8*8 bytes.
- Glyph base = {fontAddress[15:3],3'b0} + code*stride. The result is truncated to 16 bits, so addresses wrap modulo 64 KiB.
- States:
  - IDLE: in_ready_o=0. On start_i go to FILL with code=first_code, remaining=char_count, byte offset=0, lane=0. If char_count=0 or char_size=0, pulse done_o and stay in IDLE.
  - FILL: in_ready_o=1. Each accepted byte goes to lane (byte address)[1:0] and sets that sel bit; the offset increments. Go to WRITE when lane 3 is filled or the offset reaches char_size. In that same cycle, drive adr_o = word address of the current byte address.
  - WRITE: cs_o=we_o=1, with adr/dat/sel held stable until ack_i. On ack, clear sel and the data register.
    - If the glyph is finished (offset==char_size): set code+=1, remaining-=1, offset=0.
    - If remaining becomes 0, go to DONE; otherwise return to FILL.
  - DONE: pulse done_o for 1 cycle, then go to IDLE.
- A partial final word writes only the lanes it filled. Pad bytes between char_size and stride are never written.
- busy_o=1 in FILL, WRITE and DONE.

## Timing
- Reset values: cs_o=we_o=0, sel_o=0, adr_o=0, dat_o=0, in_ready_o=0, busy_o=0, done_o=0, state IDLE. A reset asserted mid-write drops cs_o on the next cycle, and the partial word is discarded.
- start_i at cycle T: busy_o=1 and in_ready_o=1 at T+1.
- The byte completing a word is accepted at cycle N; cs_o=1 from N+1 until the cycle ack_i is sampled high. in_ready_o=0 throughout WRITE, so there is at most one outstanding write.
- ack_i at cycle A: cs_o=0 at A+1, and in_ready_o=1 at A+1 if more data remains.
- ack_i arriving while cs_o=0 is ignored.
- For a final glyph acked at cycle A, done_o=1 at A+1 and busy_o=0 at A+2.
- The size multiply may be pipelined up to 3 cycles after start_i. in_ready_o stays 0 until the arithmetic is valid.

## Test plan
- 12x18 font, fontAddress=0x0000, first_code=0x41, count=1, bytes 0x00..0x23:
  - 9 writes with adr_o 0x28A..0x292, all sel_o=4'hF.
  - First dat_o=0x03020100, last dat_o=0x23222120.
  - done_o pulses once.
- 6x7 font, fontAddress=0x1003, code 0, count=2:
  - Glyph 0: adr 0x400 sel F, then adr 0x401 sel 4'b0111.
  - Glyph 1: adr 0x402 sel F, then adr 0x403 sel 4'b0111.
  - Pad bytes are untouched.
- ack_i delayed 5 cycles with in_valid_i held high: cs_o, adr_o, dat_o and sel_o stay stable; no bytes are accepted until the cycle after ack.
- char_count=0: done_o at T+1, no cs_o ever.
- start_i pulsed again mid-load: ignored, and the write sequence is unchanged.
- rst_i asserted while cs_o=1: all outputs return to reset values next cycle. A subsequent start_i runs a clean load.
